fifo_read_port: RTL and testbench
=================================

# fifo_read_port

Read-domain port of the asynchronous FIFO, running entirely on r_clk_in. It synchronizes the write pointer, owns the read pointer, and issues reads to the dual-port memory. It presents words to the consumer over a valid/ready interface. It also exports its Gray-coded read pointer so the write domain can compute full.

## Interface
- ADDR_WIDTH, 3, memory address bits; depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits (wrap bit)
- DATA_WIDTH, 8, word width
- SYNC_STAGES, 2, flops in the w_ptr synchronizer (legal ≥ 2)

Ports:
- r_clk_in  in  1  read clock
- r_reset_in  in  1  reset, asynchronous, active-high
- w_ptr_gray_in  in  ADDR_WIDTH+1  Gray-coded write pointer from write domain (asynchronous)
- r_ptr_gray_out  out  ADDR_WIDTH+1  registered Gray read pointer to write domain
- mem_rd_en_out  out  1  memory read strobe
- mem_addr_out  out  ADDR_WIDTH  memory read address
- mem_data_in  in  DATA_WIDTH  memory read data, valid one cycle after mem_rd_en_out
- r_data_out  out  DATA_WIDTH  output word, registered
- r_valid_out  out  1  r_data_out holds an unconsumed word
- r_ready_in  in  1  consumer accepts word
- r_empty_out  out  1  memory empty as seen in read domain (excludes output register)
- r_level_out  out  ADDR_WIDTH+1  words in memory as seen in read domain, 0..2**ADDR_WIDTH

## Operation
- Synchronizer: SYNC_STAGES flops on w_ptr_gray_in. Gray→binary: w_bin[i] = XOR of gray[ADDR_WIDTH:i].
- r_ptr_bin: ADDR_WIDTH+1 bits, wraps modulo 2**(ADDR_WIDTH+1). Increments by 1 on each issued read. r_ptr_gray_out = registered r_ptr_bin ^ (r_ptr_bin >> 1).
- mem_empty = (r_ptr_bin == w_bin). r_empty_out = mem_empty. r_level_out = w_bin − r_ptr_bin, modulo 2**(ADDR_WIDTH+1).
- mem_addr_out = r_ptr_bin[ADDR_WIDTH-1:0], combinational.
- FSM states:
  - EMPTY: r_valid_out=0. If !mem_empty: mem_rd_en_out=1, r_ptr_bin++, next FETCH. Otherwise stay.
  - FETCH: no read issued. Capture mem_data_in into r_data_out. Next VALID.
  - VALID: r_valid_out=1, r_data_out held.
    - If r_ready_in && !mem_empty: mem_rd_en_out=1, r_ptr_bin++, next FETCH.
    - If r_ready_in && mem_empty: next EMPTY.
    - If !r_ready_in: stay, no read issued.
- mem_rd_en_out is asserted only in EMPTY or VALID, and never when mem_empty=1.

## Timing
- Reset values: all synchronizer flops 0, r_ptr_bin 0, r_ptr_gray_out 0, state EMPTY, r_data_out 0, r_valid_out 0, mem_rd_en_out 0, r_empty_out 1, r_level_out 0.
- Reset is asynchronous and may assert in any state. Mid-operation reset aborts an in-flight FETCH and discards the output word. Pointers return to 0; the write domain must be reset concurrently.
- w_ptr_gray_in change stable before edge N reaches the compare after edge N+SYNC_STAGES−1.
- Latency, empty FIFO to first word: w_ptr visible (cycle c) → mem_rd_en_out in c → r_valid_out=1 after edge c+2.
- Sustained throughput is one word per two cycles. r_valid_out drops for exactly the FETCH cycle between back-to-back words.
- Handshake: a transfer occurs on an edge with r_valid_out && r_ready_in. r_data_out is stable while r_valid_out && !r_ready_in.
- r_ptr_gray_out updates one edge after the read that incremented r_ptr_bin, and changes exactly one bit per increment.
- Wrap: mem_addr_out goes 2**ADDR_WIDTH−1 → 0 while the wrap bit toggles. Empty compare uses the full ADDR_WIDTH+1 bits. A full FIFO (level 2**ADDR_WIDTH) is never reported empty.
- Simultaneous write arrival and handshake in VALID: the decision uses the mem_empty value of that cycle.

## Structure
- Shared package fifo_pkg:
  - state enum: EMPTY, FETCH, VALID
  - function gray2bin
  - function bin2gray
- The write-side controller uses the same package.
- One sub-module: ptr_sync, a parameterized SYNC_STAGES flop chain with async reset. It is reused by the write domain.

## Test plan
- Reset: assert r_reset_in mid-sim → all outputs at listed reset values immediately, before any clock edge.
- Single word: w_ptr_gray_in 0000→0001, mem_data_in=8'hA5 after read → mem_rd_en_out pulse with addr 0 after 2 edges; r_valid_out=1, r_data_out=A5 two edges later; r_ready_in=1 → back to EMPTY; r_ptr_gray_out=0001.
- Backpressure: 3 words present, r_ready_in=0 for 5 cycles → r_data_out stable, no mem_rd_en_out. Then ready=1 → words delivered in order, one per 2 cycles.
- Full/level: w_ptr_gray_in=1100 (bin 8), r_ptr 0 → r_level_out=8, r_empty_out=0.
- Wrap: stream 12 words through ADDR_WIDTH=3 → addresses 0..7,0..3; r_ptr_gray_out sequence is single-bit-change; wrap bit set after word 8.
- Reset during FETCH: assert reset in FETCH → r_valid_out stays 0, r_ptr_gray_out=0, state EMPTY after release.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for both pointer domains of the asynchronous FIFO:
// read-port state encoding and Gray/binary pointer conversion helpers.
package fifo_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } rd_state_t;

  // Helpers work on a fixed-width container; callers zero-extend and truncate.
  localparam int PTR_MAX_W = 32;

  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
    logic [PTR_MAX_W-1:0] bin;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing clock domains.
// Shared by the read and write ports of the FIFO.
module ptr_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sync [STAGES];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/fifo_read_port.sv
// Read-domain side of the asynchronous FIFO: synchronizes the write pointer,
// owns the read pointer, fetches words from memory and serves them valid/ready.
module fifo_read_port
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH  = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  r_clk_in,
  input  logic                  r_reset_in,
  input  logic [ADDR_WIDTH:0]   w_ptr_gray_in,
  output logic [ADDR_WIDTH:0]   r_ptr_gray_out,
  output logic                  mem_rd_en_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [DATA_WIDTH-1:0] r_data_out,
  output logic                  r_valid_out,
  input  logic                  r_ready_in,
  output logic                  r_empty_out,
  output logic [ADDR_WIDTH:0]   r_level_out
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0]         w_wptr_gray_sync;
  logic [PW-1:0]         w_wptr_bin;
  logic [PW-1:0]         r_ptr_bin;
  logic [PW-1:0]         r_ptr_gray;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  w_mem_empty;
  logic                  w_rd_issue;
  logic                  w_valid;
  rd_state_t             r_state;
  rd_state_t             w_state_nxt;

  ptr_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .i_clk (r_clk_in),
    .i_rst (r_reset_in),
    .i_d   (w_ptr_gray_in),
    .o_q   (w_wptr_gray_sync)
  );

  // Full-width compare so a completely full memory is never mistaken for empty.
  assign w_wptr_bin  = PW'(gray2bin(PTR_MAX_W'(w_wptr_gray_sync)));
  assign w_mem_empty = (r_ptr_bin == w_wptr_bin);

  always_ff @(posedge r_clk_in or posedge r_reset_in) begin
    if (r_reset_in) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: if (!w_mem_empty) w_state_nxt = FETCH;
      FETCH: w_state_nxt = VALID;
      VALID: begin
        if (r_ready_in) begin
          w_state_nxt = w_mem_empty ? EMPTY : FETCH;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    w_rd_issue = 1'b0;
    w_valid    = 1'b0;
    case (r_state)
      EMPTY: w_rd_issue = !w_mem_empty;
      VALID: begin
        w_valid    = 1'b1;
        w_rd_issue = r_ready_in && !w_mem_empty;
      end
      default: begin
        w_rd_issue = 1'b0;
        w_valid    = 1'b0;
      end
    endcase
  end

  // Gray copy lags the binary pointer by one edge and is glitch-free for the write domain.
  always_ff @(posedge r_clk_in or posedge r_reset_in) begin
    if (r_reset_in) begin
      r_ptr_bin  <= '0;
      r_ptr_gray <= '0;
    end else begin
      if (w_rd_issue) begin
        r_ptr_bin <= r_ptr_bin + PW'(1);
      end
      r_ptr_gray <= PW'(bin2gray(PTR_MAX_W'(r_ptr_bin)));
    end
  end

  always_ff @(posedge r_clk_in or posedge r_reset_in) begin
    if (r_reset_in) begin
      r_data <= '0;
    end else if (r_state == FETCH) begin
      r_data <= mem_data_in;
    end
  end

  assign mem_rd_en_out  = w_rd_issue;
  assign mem_addr_out   = r_ptr_bin[ADDR_WIDTH-1:0];
  assign r_ptr_gray_out = r_ptr_gray;
  assign r_data_out     = r_data;
  assign r_valid_out    = w_valid;
  assign r_empty_out    = w_mem_empty;
  assign r_level_out    = w_wptr_bin - r_ptr_bin;

endmodule

// File: tb/tb_fifo_read_port.sv
// Bench for fifo_read_port: models the write domain and the dual-port memory,
// and scores delivered words against a queue filled as words are written.
module tb_fifo_read_port;

  localparam int AW = 3;
  localparam int DW = 8;
  localparam int SS = 2;
  localparam int PW = AW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] w_ptr_gray;
  logic [PW-1:0] r_ptr_gray;
  logic          rd_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] mem_data = '0;
  logic [DW-1:0] r_data;
  logic          r_valid;
  logic          r_ready;
  logic          r_empty;
  logic [PW-1:0] level;

  logic [DW-1:0] mem [8];
  logic [DW-1:0] sb_q [$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            exp_rd = 0;
  logic [PW-1:0] wptr;
  logic [PW-1:0] prev_gray = '0;
  logic [DW-1:0] head;
  int            pat [5] = '{0, 1, 0, 1, 0};
  logic          seen;

  fifo_read_port #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .SYNC_STAGES (SS)
  ) dut (
    .r_clk_in       (clk),
    .r_reset_in     (rst),
    .w_ptr_gray_in  (w_ptr_gray),
    .r_ptr_gray_out (r_ptr_gray),
    .mem_rd_en_out  (rd_en),
    .mem_addr_out   (addr),
    .mem_data_in    (mem_data),
    .r_data_out     (r_data),
    .r_valid_out    (r_valid),
    .r_ready_in     (r_ready),
    .r_empty_out    (r_empty),
    .r_level_out    (level)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Memory returns data one cycle after the read strobe.
  always @(posedge clk) begin
    if (rd_en) mem_data <= mem[addr];
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_gray = '0;
    end else begin
      if (rd_en) begin
        check("rd_addr", 32'(addr), 32'(exp_rd % 8));
        check("rd_while_empty", 32'(r_empty), 32'd0);
        exp_rd++;
      end
      if (r_ptr_gray != prev_gray) begin
        check("gray_one_bit", 32'($countones(prev_gray ^ r_ptr_gray)), 32'd1);
        prev_gray = r_ptr_gray;
      end
      if (r_valid && r_ready) begin
        if (sb_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
        else check("rd_data", 32'(r_data), 32'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    mem[wptr[AW-1:0]] = d;
    sb_q.push_back(d);
    wptr       = wptr + PW'(1);
    w_ptr_gray = to_gray(wptr);
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((sb_q.size() != 0 || r_valid) && k < budget) begin
      tick(1);
      k++;
    end
    check("drain_timeout", 32'(sb_q.size() != 0 || r_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(r_valid), 32'd0);
    check({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    check({tag, "_empty"}, 32'(r_empty), 32'd1);
    check({tag, "_level"}, 32'(level), 32'd0);
    check({tag, "_gray"},  32'(r_ptr_gray), 32'd0);
    check({tag, "_data"},  32'(r_data), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = '0;
    rst        = 1'b0;
    w_ptr_gray = '0;
    r_ready    = 1'b1;
    wptr       = '0;
    #1 rst = 1'b1;
    #1 check_reset_outputs("rst0");
    tick(2);
    rst = 1'b0;
    tick(1);

    // Single word
    check("sw_pre_empty", 32'(r_empty), 32'd1);
    push(8'hA5);
    tick(1);
    check("sw_rd_early", 32'(rd_en), 32'd0);
    tick(1);
    check("sw_rd_en", 32'(rd_en), 32'd1);
    check("sw_level", 32'(level), 32'd1);
    check("sw_empty", 32'(r_empty), 32'd0);
    tick(1);
    check("sw_fetch_valid", 32'(r_valid), 32'd0);
    check("sw_fetch_rd", 32'(rd_en), 32'd0);
    tick(1);
    check("sw_valid", 32'(r_valid), 32'd1);
    check("sw_data", 32'(r_data), 32'hA5);
    tick(1);
    check("sw_done_valid", 32'(r_valid), 32'd0);
    check("sw_gray", 32'(r_ptr_gray), 32'h1);
    check("sw_done_empty", 32'(r_empty), 32'd1);

    // Backpressure with three words waiting
    r_ready = 1'b0;
    push(8'hB0);
    tick(1);
    push(8'hB1);
    tick(1);
    push(8'hB2);
    tick(4);
    check("bp_head_valid", 32'(r_valid), 32'd1);
    check("bp_head_data", 32'(r_data), 32'hB0);
    head = r_data;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("bp_hold_valid", 32'(r_valid), 32'd1);
      check("bp_hold_data", 32'(r_data), 32'(head));
      check("bp_hold_rd", 32'(rd_en), 32'd0);
    end
    r_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("bp_valid_pattern", 32'(r_valid), 32'(pat[i]));
    end
    check("bp_empty", 32'(r_empty), 32'd1);
    check("bp_level", 32'(level), 32'd0);

    // Full memory seen from reset, then wrap
    rst        = 1'b1;
    w_ptr_gray = '0;
    wptr       = '0;
    sb_q.delete();
    exp_rd     = 0;
    tick(2);
    rst = 1'b0;
    tick(1);
    for (int i = 0; i < 8; i++) begin
      mem[i] = 8'(8'h10 + i);
      sb_q.push_back(8'(8'h10 + i));
    end
    wptr       = PW'(8);
    w_ptr_gray = to_gray(wptr);
    tick(1);
    check("full_level_early", 32'(level), 32'd0);
    tick(1);
    check("full_level", 32'(level), 32'd8);
    check("full_empty", 32'(r_empty), 32'd0);
    check("full_rd_en", 32'(rd_en), 32'd1);
    check("full_addr", 32'(addr), 32'd0);
    wait_drain(60);
    check("wrap_gray8", 32'(r_ptr_gray), 32'hC);
    for (int i = 0; i < 4; i++) begin
      push(8'(8'h20 + i));
      tick(1);
    end
    wait_drain(60);
    check("wrap_gray12", 32'(r_ptr_gray), 32'(to_gray(PW'(12))));
    check("wrap_rd_count", 32'(exp_rd), 32'd12);

    // Reset while a fetch is in flight
    push(8'h5A);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick(1);
      seen = rd_en;
    end
    check("rf_rd_seen", 32'(seen), 32'd1);
    tick(1);
    check("rf_in_fetch", 32'(r_valid), 32'd0);
    #2;
    rst        = 1'b1;
    w_ptr_gray = '0;
    #1;
    check_reset_outputs("rf_async");
    sb_q.delete();
    exp_rd = 0;
    wptr   = '0;
    tick(2);
    rst = 1'b0;
    tick(4);
    check("rf_after_valid", 32'(r_valid), 32'd0);
    check("rf_after_gray", 32'(r_ptr_gray), 32'd0);
    check("rf_after_empty", 32'(r_empty), 32'd1);
    check("rf_after_rd", 32'(exp_rd), 32'd0);

    check("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
